// File: rtl/axis_insert_header_gen.sv
// AXI-Stream header inserter: prepends 0..DATA_BYTE_WD header bytes to each packet with byte realignment.
// Define AXIS_INS_HDR_CHK_EN to add a sticky err output flagging illegal keep patterns.
module axis_insert_header_gen #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      data_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert
`ifdef AXIS_INS_HDR_CHK_EN
    ,
    output logic                    err
`endif
);

    typedef enum logic [1:0] {
        S_HDR,
        S_DATA,
        S_TAIL
    } state_t;

    localparam logic [BYTE_CNT_WD:0] FULL_CNT = (BYTE_CNT_WD + 1)'(DATA_BYTE_WD);

    function automatic logic [BYTE_CNT_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [BYTE_CNT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + BYTE_CNT_WD'(k[i]);
        return c;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] top_ones(input logic [BYTE_CNT_WD-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} >> n);
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] low_ones(input logic [BYTE_CNT_WD-1:0] n);
        return ~({DATA_BYTE_WD{1'b1}} << n);
    endfunction

    function automatic logic [DATA_WD-1:0] lane_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      res_q, res_d;
    logic [BYTE_CNT_WD-1:0]  hcnt_q, hcnt_d;
    logic [BYTE_CNT_WD-1:0]  tcnt_q, tcnt_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [DATA_BYTE_WD-1:0] keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;

    logic                    out_free;
    logic                    in_hs;
    logic                    ins_hs;
    logic [BYTE_CNT_WD-1:0]  kcnt;
    logic [BYTE_CNT_WD-1:0]  ins_cnt;
    logic [BYTE_CNT_WD:0]    sum_w;
    logic [DATA_WD-1:0]      word;
    logic [DATA_BYTE_WD-1:0] wkeep;

    assign out_free     = !valid_out_q || ready_out;
    assign ready_insert = !rst && (state_q == S_HDR);
    assign ready_in     = !rst && (state_q == S_DATA) && out_free;
    assign in_hs        = valid_in && ready_in;
    assign ins_hs       = valid_insert && ready_insert;
    assign kcnt         = popcnt(keep_in);
    assign ins_cnt      = popcnt(keep_insert);
    assign sum_w        = (BYTE_CNT_WD + 1)'(hcnt_q) + (BYTE_CNT_WD + 1)'(kcnt);

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign keep_out  = keep_out_q;
    assign last_out  = last_out_q;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        res_d       = res_q;
        hcnt_d      = hcnt_q;
        tcnt_d      = tcnt_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        word        = '0;
        wkeep       = '0;

        // A free output register either held nothing or is being consumed this cycle.
        if (out_free) valid_out_d = 1'b0;

        unique case (state_q)
            S_HDR: begin
                if (ins_hs) begin
                    res_d   = data_insert & lane_mask(low_ones(ins_cnt));
                    hcnt_d  = ins_cnt;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (in_hs) begin
                    word  = (res_q << (8 * (DATA_BYTE_WD - int'(hcnt_q))))
                          | (data_in >> (8 * int'(hcnt_q)));
                    wkeep = '1;
                    res_d = data_in & lane_mask(low_ones(hcnt_q));
                    valid_out_d = 1'b1;
                    last_out_d  = 1'b0;
                    if (last_in) begin
                        if (sum_w <= FULL_CNT) begin
                            wkeep      = top_ones(sum_w[BYTE_CNT_WD-1:0]);
                            last_out_d = 1'b1;
                            state_d    = S_HDR;
                        end else begin
                            tcnt_d  = BYTE_CNT_WD'(sum_w - FULL_CNT);
                            state_d = S_TAIL;
                        end
                    end
                    data_out_d = word & lane_mask(wkeep);
                    keep_out_d = wkeep;
                end
            end
            S_TAIL: begin
                if (out_free) begin
                    word        = res_q << (8 * (DATA_BYTE_WD - int'(hcnt_q)));
                    wkeep       = top_ones(tcnt_q);
                    data_out_d  = word & lane_mask(wkeep);
                    keep_out_d  = wkeep;
                    last_out_d  = 1'b1;
                    valid_out_d = 1'b1;
                    state_d     = S_HDR;
                end
            end
            default: state_d = S_HDR;
        endcase
    end

`ifdef AXIS_INS_HDR_CHK_EN
    logic err_q, err_d;
    logic ins_bad;
    logic in_bad;

    assign err = err_q;

    always_comb begin
        ins_bad = keep_insert != low_ones(ins_cnt);
        in_bad  = last_in ? ((keep_in == '0) || (keep_in != top_ones(kcnt)))
                          : (keep_in != '1);
        err_d   = err_q | (ins_hs && ins_bad) | (in_hs && in_bad);
    end

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives in always_comb.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HDR;
            res_q       <= '0;
            hcnt_q      <= '0;
            tcnt_q      <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            hcnt_q      <= hcnt_d;
            tcnt_q      <= tcnt_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
        end
    end

endmodule
